// File: rtl/instr_fetcher_pkg.sv
// Shared constants and helpers for the instruction fetcher: JAL opcode, default
// reset PC, fetch FSM states and J-type immediate extraction.
package instr_fetcher_pkg;

   localparam logic [6:0]  OP_JAL           = 7'b1101111;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } fetch_state_t;

   // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} in instr[31:12]
   function automatic logic [31:0] j_imm(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/instr_fetcher_queue.sv
// Circular instruction queue: push at tail, pop at head, synchronous flush.
// Head data reads as zero whenever the queue is empty.
module instr_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic          valid,
   output logic [W-1:0]  head_data,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          do_push;
   logic          do_pop;

   assign do_push   = push && (count != (AW+1)'(DEPTH));
   assign do_pop    = pop && (count != '0);
   assign valid     = (count != '0);
   assign head_data = valid ? mem[head] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (en) begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
               2'b10:   count <= count + (AW+1)'(1);
               2'b01:   count <= count - (AW+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset: contents are only visible through a valid head.
   always_ff @(posedge clk) begin
      if (!rst && en && !flush && do_push) mem[tail] <= push_data;
   end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetcher: holds the PC, issues one cache read at a time, queues
// returned words with their PC for the decoder, and redirects on a ROB flush.
module instr_fetcher
   import instr_fetcher_pkg::*;
#(
   parameter int          IQ_DEPTH = 8,
   parameter int          IQ_AW    = 3,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rob_clear,
   input  logic [31:0] rob_new_pc,
   output logic        out_cache_req,
   output logic [31:0] out_cache_addr,
   input  logic        in_cache_ready,
   input  logic [31:0] in_cache_instr,
   input  logic [31:0] in_cache_addr,
   output logic        out_dec_valid,
   output logic [31:0] out_dec_instr,
   output logic [31:0] out_dec_pc,
   input  logic        in_dec_pop
);

   fetch_state_t  state;
   fetch_state_t  state_next;
   logic [31:0]   pc;
   logic [31:0]   addr_q;
   logic [31:0]   next_pc;
   logic          issue;
   logic          accept;
   logic [IQ_AW:0] q_count;
   logic [63:0]   q_head;

   assign out_cache_req  = (state == ST_WAIT);
   assign out_cache_addr = addr_q;
   assign out_dec_instr  = q_head[63:32];
   assign out_dec_pc     = q_head[31:0];

   assign next_pc = (in_cache_instr[6:0] == OP_JAL) ? addr_q + j_imm(in_cache_instr)
                                                    : addr_q + 32'd4;

   always_ff @(posedge clk) begin
      if (rst)      state <= ST_IDLE;
      else if (rdy) state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            // No fetch is in flight here, so a free slot guarantees room for the reply.
            if (q_count < (IQ_AW+1)'(IQ_DEPTH)) begin
               issue      = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (in_cache_ready && (in_cache_addr == addr_q)) begin
               accept     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (rob_clear) begin
         issue      = 1'b0;
         accept     = 1'b0;
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         addr_q <= 32'h0;
      end else if (rdy) begin
         if (rob_clear) begin
            pc <= rob_new_pc;
         end else begin
            if (issue)  addr_q <= pc;
            if (accept) pc     <= next_pc;
         end
      end
   end

   instr_queue #(
      .DEPTH(IQ_DEPTH),
      .AW   (IQ_AW),
      .W    (64)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .en       (rdy),
      .flush    (rob_clear),
      .push     (accept),
      .push_data({in_cache_instr, addr_q}),
      .pop      (in_dec_pop),
      .valid    (out_dec_valid),
      .head_data(q_head),
      .count    (q_count)
   );

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: a table of per-cycle vectors plus
// hand-written sequences for queue-full back-pressure and ROB flush.
module tb_instr_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        rob_clear;
   logic [31:0] rob_new_pc;
   logic        out_cache_req;
   logic [31:0] out_cache_addr;
   logic        in_cache_ready;
   logic [31:0] in_cache_instr;
   logic [31:0] in_cache_addr;
   logic        out_dec_valid;
   logic [31:0] out_dec_instr;
   logic [31:0] out_dec_pc;
   logic        in_dec_pop;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_fetcher #(.IQ_DEPTH(8), .IQ_AW(3), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .rob_clear     (rob_clear),
      .rob_new_pc    (rob_new_pc),
      .out_cache_req (out_cache_req),
      .out_cache_addr(out_cache_addr),
      .in_cache_ready(in_cache_ready),
      .in_cache_instr(in_cache_instr),
      .in_cache_addr (in_cache_addr),
      .out_dec_valid (out_dec_valid),
      .out_dec_instr (out_dec_instr),
      .out_dec_pc    (out_dec_pc),
      .in_dec_pop    (in_dec_pop)
   );

   typedef struct {
      logic        rdy;
      logic        ready;
      logic [31:0] instr;
      logic [31:0] raddr;
      logic        pop;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic rd, logic [31:0] ins, logic [31:0] ra, logic p,
                               logic er, logic [31:0] ea, logic ev, logic [31:0] ei,
                               logic [31:0] ep);
      vec_t v;
      v.rdy = r; v.ready = rd; v.instr = ins; v.raddr = ra; v.pop = p;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; rob_clear = 1'b0; rob_new_pc = 32'h0;
      in_cache_ready = 1'b0; in_cache_instr = 32'h0; in_cache_addr = 32'h0;
      in_dec_pop = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rdy = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_req(input string name, input int max_cycles);
      int n = 0;
      while (!out_cache_req && n < max_cycles) begin
         tick();
         n++;
      end
      check(name, {31'h0, out_cache_req}, 32'h1);
   endtask

   task automatic check_outputs(input string tag, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep);
      check({tag, ".req"},   {31'h0, out_cache_req}, {31'h0, er});
      check({tag, ".addr"},  out_cache_addr, ea);
      check({tag, ".valid"}, {31'h0, out_dec_valid}, {31'h0, ev});
      check({tag, ".instr"}, out_dec_instr, ei);
      check({tag, ".pc"},    out_dec_pc, ep);
   endtask

   initial begin
      // Table: inputs applied before an edge, expected outputs just after it.
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h00,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h00,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h00,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h00,0,32'h0,32'h0));
      vecs.push_back(mk(1,1,32'h13,32'h0,0, 0,32'h00,1,32'h13,32'h0));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h04,1,32'h13,32'h0));
      vecs.push_back(mk(1,1,32'h93,32'h4,1, 0,32'h04,1,32'h93,32'h4));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h08,1,32'h93,32'h4));
      vecs.push_back(mk(1,1,32'h113,32'h8,0, 0,32'h08,1,32'h93,32'h4));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h0C,1,32'h93,32'h4));
      vecs.push_back(mk(1,1,32'h193,32'hC,0, 0,32'h0C,1,32'h93,32'h4));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h10,1,32'h93,32'h4));
      // wrong response address is discarded
      vecs.push_back(mk(1,1,32'hDEAD,32'h14,0, 1,32'h10,1,32'h93,32'h4));
      // rdy low: strobes and pops ignored
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,1,32'h0080006F,32'h10,1, 1,32'h10,1,32'h93,32'h4));
      // JAL +8 at 0x10 with push+pop at count 3
      vecs.push_back(mk(1,1,32'h0080006F,32'h10,1, 0,32'h10,1,32'h113,32'h8));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h18,1,32'h113,32'h8));
      vecs.push_back(mk(1,0,32'h0,32'h0,1, 1,32'h18,1,32'h193,32'hC));
      // push+pop at count 2
      vecs.push_back(mk(1,1,32'h213,32'h18,1, 0,32'h18,1,32'h0080006F,32'h10));
      vecs.push_back(mk(1,0,32'h0,32'h0,1, 1,32'h1C,1,32'h213,32'h18));
      vecs.push_back(mk(1,0,32'h0,32'h0,1, 1,32'h1C,0,32'h0,32'h0));
      vecs.push_back(mk(1,0,32'h0,32'h0,1, 1,32'h1C,0,32'h0,32'h0));
      // JAL -8 at 0x1C -> 0x14
      vecs.push_back(mk(1,1,32'hFF9FF06F,32'h1C,0, 0,32'h1C,1,32'hFF9FF06F,32'h1C));
      vecs.push_back(mk(1,0,32'h0,32'h0,0, 1,32'h14,1,32'hFF9FF06F,32'h1C));

      do_reset();
      check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

      foreach (vecs[i]) begin
         rdy = vecs[i].rdy;
         in_cache_ready = vecs[i].ready;
         in_cache_instr = vecs[i].instr;
         in_cache_addr  = vecs[i].raddr;
         in_dec_pop     = vecs[i].pop;
         tick();
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                       vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc);
      end

      // Queue fill: decoder never pops, exactly eight words accepted.
      do_reset();
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         wait_req($sformatf("fill%0d.req_seen", i), 10);
         check($sformatf("fill%0d.addr", i), out_cache_addr, 32'(i * 4));
         in_cache_ready = 1'b1;
         in_cache_addr  = 32'(i * 4);
         in_cache_instr = 32'h13 | (32'(i) << 20);
         tick();
         in_cache_ready = 1'b0;
      end
      for (int c = 0; c < 10; c++) begin
         check($sformatf("full.req_low%0d", c), {31'h0, out_cache_req}, 32'h0);
         tick();
      end
      check("full.head_instr", out_dec_instr, 32'h13);
      check("full.head_pc", out_dec_pc, 32'h0);
      in_dec_pop = 1'b1;
      tick();
      in_dec_pop = 1'b0;
      check("pop.req_still_low", {31'h0, out_cache_req}, 32'h0);
      check("pop.head_pc", out_dec_pc, 32'h4);
      check("pop.head_instr", out_dec_instr, 32'h00100013);
      tick();
      check("refill.req", {31'h0, out_cache_req}, 32'h1);
      check("refill.addr", out_cache_addr, 32'h20);

      // Flush while waiting, with a same-cycle response and pop.
      rob_clear = 1'b1; rob_new_pc = 32'h100;
      in_cache_ready = 1'b1; in_cache_addr = 32'h20; in_cache_instr = 32'h33;
      in_dec_pop = 1'b1;
      tick();
      idle_inputs();
      check("clear.valid", {31'h0, out_dec_valid}, 32'h0);
      check("clear.req", {31'h0, out_cache_req}, 32'h0);
      tick();
      check("clear.req_next", {31'h0, out_cache_req}, 32'h1);
      check("clear.addr_next", out_cache_addr, 32'h100);
      check("clear.still_empty", {31'h0, out_dec_valid}, 32'h0);
      in_cache_ready = 1'b1; in_cache_addr = 32'h100; in_cache_instr = 32'h4B3;
      tick();
      in_cache_ready = 1'b0;
      check("redir.head_instr", out_dec_instr, 32'h4B3);
      check("redir.head_pc", out_dec_pc, 32'h100);
      tick();
      in_dec_pop = 1'b1;
      check("redir.next_addr", out_cache_addr, 32'h104);
      tick();
      in_dec_pop = 1'b0;
      check("redir.drained", {31'h0, out_dec_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
